// File: rtl/led_frame_serializer.sv
// led_frame_serializer: accepts 24-bit GRB pixels over valid/ready and
// streams them MSB-first, one bit per fixed slot of BIT_CYCLES clocks.
// After NUM_LEDS pixels the line is held low for RESET_CYCLES clocks
// (latch period), and then frame_done pulses.
module led_frame_serializer #(
    parameter int BIT_CYCLES   = 61,
    parameter int NUM_LEDS     = 8,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        un_encoded_data,
    output logic        bit_strobe,
    output logic        sending_data,
    output logic        frame_done,
    output logic        underrun
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_SHIFT      = 2'd2,
        ST_LATCH      = 2'd3
    } state_t;

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] LEDS     = PW'(NUM_LEDS);
    localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [4:0]    BIT_LAST = 5'd23;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_shreg;
    logic [23:0] r_hold;
    logic        r_hold_valid;
    logic [CW-1:0] r_cyc_cnt;
    logic [4:0]  r_bit_cnt;
    logic [PW-1:0] r_sent_cnt;
    logic [PW-1:0] r_acc_cnt;
    logic [LW-1:0] r_lat_cnt;
    logic        r_data;
    logic        r_strobe;
    logic        r_done;
    logic        r_underrun;

    logic        w_frame_active;
    logic        w_accept;
    logic        w_slot_end;
    logic        w_start_frame;
    logic        w_load;
    logic        w_shift;
    logic        w_latch_entry;
    logic        w_set_underrun;
    logic        w_finish;

    assign w_frame_active  = (r_state == ST_WAIT_FIRST) || (r_state == ST_SHIFT);
    assign pixel_ready     = w_frame_active && !r_hold_valid && (r_acc_cnt < LEDS);
    assign w_accept        = pixel_valid && pixel_ready;
    assign w_slot_end      = (r_cyc_cnt == CYC_LAST);

    assign un_encoded_data = r_data;
    assign bit_strobe      = r_strobe;
    assign sending_data    = (r_state == ST_SHIFT);
    assign frame_done      = r_done;
    assign underrun        = r_underrun;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-edge control decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_start_frame  = 1'b0;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        w_latch_entry  = 1'b0;
        w_set_underrun = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the frame_done pulse is ignored.
                if (start && !r_done) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = ST_WAIT_FIRST;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_FIRST: begin
                if (r_hold_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_WAIT_FIRST;
                end
            end
            ST_SHIFT: begin
                if (!w_slot_end) begin
                    w_state_nxt = ST_SHIFT;
                end else if (r_bit_cnt != BIT_LAST) begin
                    w_shift = 1'b1;
                end else if (r_sent_cnt == LEDS) begin
                    w_latch_entry = 1'b1;
                    w_state_nxt   = ST_LATCH;
                end else if (r_hold_valid) begin
                    w_load = 1'b1;
                end else begin
                    // Next pixel missing at a pixel boundary: abandon the rest.
                    w_latch_entry  = 1'b1;
                    w_set_underrun = 1'b1;
                    w_state_nxt    = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LATCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-entry hold buffer and per-frame pixel accounting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold       <= 24'd0;
            r_hold_valid <= 1'b0;
            r_acc_cnt    <= '0;
            r_sent_cnt   <= '0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold       <= pixel_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
            if (w_start_frame) begin
                r_acc_cnt <= '0;
            end else if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + PW'(1);
            end
            if (w_start_frame) begin
                r_sent_cnt <= '0;
            end else if (w_load) begin
                r_sent_cnt <= r_sent_cnt + PW'(1);
            end
            if (w_start_frame) begin
                r_underrun <= 1'b0;
            end else if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Bit-slot timing, shift register and the registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg   <= 24'd0;
            r_data    <= 1'b0;
            r_cyc_cnt <= '0;
            r_bit_cnt <= 5'd0;
            r_strobe  <= 1'b0;
        end else begin
            r_strobe <= w_load || w_shift;
            if (w_load) begin
                r_shreg   <= r_hold;
                r_data    <= r_hold[23];
                r_cyc_cnt <= '0;
                r_bit_cnt <= 5'd0;
            end else if (w_shift) begin
                r_shreg   <= r_shreg << 1;
                r_data    <= r_shreg[22];
                r_cyc_cnt <= '0;
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end else if (w_latch_entry) begin
                r_data    <= 1'b0;
                r_cyc_cnt <= '0;
                r_bit_cnt <= 5'd0;
            end else if (r_state == ST_SHIFT) begin
                r_cyc_cnt <= r_cyc_cnt + CW'(1);
            end
        end
    end

    // Latch-period counter and the frame completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if ((r_state == ST_LATCH) && !w_finish) begin
                r_lat_cnt <= r_lat_cnt + LW'(1);
            end else begin
                r_lat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: table of frame scenarios checked through a
// bit scoreboard, plus hand-written reset, and single-LED sequences.
module tb_led_frame_serializer;

    localparam int B     = 61;
    localparam int N     = 2;
    localparam int R     = 100;
    localparam int LIMIT = 4000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        un_encoded_data;
    logic        bit_strobe;
    logic        sending_data;
    logic        frame_done;
    logic        underrun;

    logic        s_start;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_line;
    logic        s_strobe;
    logic        s_send;
    logic        s_done;
    logic        s_underrun;

    int checks;
    int errors;
    int cyc;

    logic exp_q[$];
    int   xfers;
    int   strobe_cnt;
    int   first_strobe;
    int   last_strobe;
    int   done_cyc;
    int   ur_cyc;
    int   line_err;
    logic last_bit;

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        bit          late;
        bit          keep;
        bit          poke;
        int          exp_strobes;
        int          exp_xfers;
        bit          exp_underrun;
        int          exp_delay;
    } vec_t;

    vec_t vecs[4];

    led_frame_serializer #(.BIT_CYCLES(B), .NUM_LEDS(N), .RESET_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .start(start), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .un_encoded_data(un_encoded_data), .bit_strobe(bit_strobe),
        .sending_data(sending_data), .frame_done(frame_done), .underrun(underrun)
    );

    led_frame_serializer #(.BIT_CYCLES(2), .NUM_LEDS(1), .RESET_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .start(s_start), .pixel_data(s_data),
        .pixel_valid(s_valid), .pixel_ready(s_ready),
        .un_encoded_data(s_line), .bit_strobe(s_strobe),
        .sending_data(s_send), .frame_done(s_done), .underrun(s_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        xfers        = 0;
        strobe_cnt   = 0;
        first_strobe = -1;
        last_strobe  = -1;
        done_cyc     = -1;
        ur_cyc       = -1;
        line_err     = 0;
        last_bit     = 1'b0;
    endtask

    // Scoreboard monitor: pushes expected bits on each transfer, pops on each strobe.
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pixel_valid && pixel_ready) begin
                    xfers++;
                    for (int i = 23; i >= 0; i--) exp_q.push_back(pixel_data[i]);
                end
                if (bit_strobe) begin
                    if (first_strobe < 0) first_strobe = cyc;
                    else chk("slot_len", cyc - last_strobe, B);
                    last_strobe = cyc;
                    strobe_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("strobe_without_pixel", strobe_cnt, 0);
                    end else begin
                        chk("bit", un_encoded_data, exp_q.pop_front());
                    end
                    last_bit = un_encoded_data;
                end else if (sending_data && (un_encoded_data !== last_bit)) begin
                    line_err++;
                end
                if (!sending_data && un_encoded_data) line_err++;
                if (frame_done && done_cyc < 0) done_cyc = cyc;
                if (underrun && ur_cyc < 0) ur_cyc = cyc;
            end
        end
    end

    task automatic wait_xfers(input int n);
        for (int t = 0; t < 200; t++) begin
            if (xfers >= n) break;
            @(posedge clk); #1;
        end
        chk("xfer_reached", (xfers >= n), 1);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        bit seen;
        int lat_t;
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pixel_valid = 1'b1;
        pixel_data  = v.p0;
        wait_xfers(1);
        if (v.late) begin
            pixel_valid = 1'b0;
            for (int t = 0; t < B * 24 + 20; t++) begin
                if (underrun) break;
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk($sformatf("v%0d_underrun_rise", idx), underrun, 1);
            chk($sformatf("v%0d_underrun_time", idx), ur_cyc - first_strobe, 24 * B);
            chk($sformatf("v%0d_late_not_ready", idx), pixel_ready, 0);
            pixel_valid = 1'b1;
            pixel_data  = v.p1;
        end else begin
            pixel_data = v.p1;
            wait_xfers(2);
            if (v.keep) chk($sformatf("v%0d_ready_drop", idx), pixel_ready, 0);
            else pixel_valid = 1'b0;
        end
        seen  = 1'b0;
        lat_t = 0;
        for (int t = 0; t < LIMIT; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (v.keep) pixel_data = 24'($urandom);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if (v.poke) begin
                if (t == 300) start = 1'b1;
                if (!sending_data && strobe_cnt == v.exp_strobes) begin
                    lat_t++;
                    if (lat_t == 10) start = 1'b1;
                end
            end
        end
        chk($sformatf("v%0d_frame_done_seen", idx), seen, 1);
        if (v.poke) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            chk($sformatf("v%0d_done_cycle_start_ignored", idx), pixel_ready, 0);
        end else begin
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_done_pulse_width", idx), frame_done, 0);
        pixel_valid = 1'b0;
        chk($sformatf("v%0d_strobes", idx), strobe_cnt, v.exp_strobes);
        chk($sformatf("v%0d_xfers", idx), xfers, v.exp_xfers);
        chk($sformatf("v%0d_underrun", idx), underrun, v.exp_underrun);
        chk($sformatf("v%0d_done_delay", idx), done_cyc - first_strobe, v.exp_delay);
        chk($sformatf("v%0d_queue_left", idx), exp_q.size(), 0);
        chk($sformatf("v%0d_line_errors", idx), line_err, 0);
    endtask

    initial begin
        logic l_line[56];
        logic l_send[56];
        logic l_strb[56];
        logic l_done[56];
        int   nmis;
        int   nsend;
        int   nstrb;
        int   ndone;
        bit   got;

        checks = 0; errors = 0; cyc = 0;
        reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_data = 24'd0;
        s_start = 1'b0; s_valid = 1'b0; s_data = 24'd0;

        vecs[0] = '{24'hFF0000, 24'h00AA55, 1'b0, 1'b0, 1'b0, 48, 2, 1'b0, 48 * B + R};
        vecs[1] = '{24'h123456, 24'hA5C3F0, 1'b0, 1'b1, 1'b0, 48, 2, 1'b0, 48 * B + R};
        vecs[2] = '{24'hC0FFEE, 24'h0F0F0F, 1'b1, 1'b0, 1'b0, 24, 1, 1'b1, 24 * B + R};
        vecs[3] = '{24'hFF0000, 24'h00AA55, 1'b0, 1'b0, 1'b1, 48, 2, 1'b0, 48 * B + R};

        #2;
        chk("rst_line", un_encoded_data, 0);
        chk("rst_ready", pixel_ready, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_sending", sending_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", pixel_ready, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

        // Reset during slot 10 of the first pixel, then a fresh frame.
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pixel_valid = 1'b1;
        pixel_data  = 24'h3C5A96;
        wait_xfers(1);
        pixel_data = 24'h00FF00;
        wait_xfers(2);
        pixel_valid = 1'b0;
        for (int t = 0; t < B * 12; t++) begin
            if (strobe_cnt >= 10) break;
            @(posedge clk); #1;
        end
        chk("mid_reset_slot_reached", strobe_cnt, 10);
        #7 reset = 1'b1;
        #1;
        chk("mid_reset_line", un_encoded_data, 0);
        chk("mid_reset_sending", sending_data, 0);
        chk("mid_reset_ready", pixel_ready, 0);
        chk("mid_reset_underrun", underrun, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
        run_frame(vecs[0], 4);

        // Single LED, two-clock slots, pixel 0x800001.
        @(posedge clk); #1 s_start = 1'b1;
        s_valid = 1'b1;
        s_data  = 24'h800001;
        @(posedge clk); #1 s_start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (s_strobe) begin
                got = 1'b1;
                break;
            end
        end
        chk("led1_first_strobe", got, 1);
        for (int k = 0; k < 56; k++) begin
            l_line[k] = s_line;
            l_send[k] = s_send;
            l_strb[k] = s_strobe;
            l_done[k] = s_done;
            if (k == 2) s_valid = 1'b0;
            @(negedge clk);
        end
        nmis = 0; nsend = 0; nstrb = 0; ndone = 0;
        for (int k = 0; k < 56; k++) begin
            if (l_line[k] !== ((k < 2) || (k >= 46 && k < 48))) nmis++;
            if (l_send[k] !== (k < 48)) nsend++;
            if (l_strb[k] !== ((k < 48) && (k % 2 == 0))) nstrb++;
            if (l_done[k] !== (k == 52)) ndone++;
        end
        chk("led1_line_pattern_errs", nmis, 0);
        chk("led1_sending_errs", nsend, 0);
        chk("led1_strobe_errs", nstrb, 0);
        chk("led1_done_errs", ndone, 0);
        chk("led1_underrun", s_underrun, 0);
        chk("led1_ready_idle", s_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_frame_serializer.md
Name: led_frame_serializer

Overview:
- Upstream feeder for SingleBinaryEncoder.
- Accepts 24-bit GRB pixels over a valid/ready handshake and streams them MSB-first (G7 first, B0 last).
- Each bit is held for one fixed bit slot of BIT_CYCLES clocks (61 × 20 ns = 1220 ns at 50 MHz) on un_encoded_data.
- After NUM_LEDS pixels, drives the low latch/reset period, then reports frame completion.

Parameters:
- BIT_CYCLES, 61, clocks per bit slot; must be ≥ 2.
- NUM_LEDS, 8, pixels per frame; must be ≥ 1.
- RESET_CYCLES, 2500, clocks of forced-low latch period after the last bit (50 µs at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle request to begin a frame; honoured only in IDLE.
- pixel_data  input  24  GRB pixel: [23:16] G, [15:8] R, [7:0] B.
- pixel_valid  input  1  pixel_data is valid.
- pixel_ready  output  1  block accepts pixel_data this cycle.
- un_encoded_data  output  1  current bit to the encoder; 0 outside SHIFT.
- bit_strobe  output  1  1-cycle pulse on the first clock of every bit slot.
- sending_data  output  1  high while in SHIFT.
- frame_done  output  1  1-cycle pulse at the end of LATCH.
- underrun  output  1  sticky error flag; cleared by an accepted start.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset (asynchronous, active-high), mid-frame included: state=IDLE, all outputs 0, hold buffer empty, all counters 0. The frame is abandoned and the line is left low.
- Internal storage:
  - 24-bit shift register shreg.
  - One-entry hold buffer hold/hold_valid.
  - Counters: cyc_cnt (0..BIT_CYCLES-1), bit_cnt (0..23), sent_cnt (pixels loaded into shreg), acc_cnt (pixels accepted), lat_cnt.
- Handshake:
  - pixel_ready = frame_active && !hold_valid && acc_cnt < NUM_LEDS. It is combinational from registers, not from pixel_valid.
  - Transfer occurs when pixel_valid && pixel_ready at a rising edge: hold <= pixel_data, hold_valid <= 1, acc_cnt++.
  - Exactly NUM_LEDS transfers per frame.
  - frame_active is 1 in WAIT_FIRST and SHIFT.
- IDLE:
  - On start: acc_cnt=sent_cnt=0, underrun<=0, go to WAIT_FIRST.
  - start in any other state is ignored.
- WAIT_FIRST:
  - When hold_valid=1: shreg<=hold, un_encoded_data<=hold[23], hold_valid<=0, sent_cnt=1, cyc_cnt=bit_cnt=0, bit_strobe<=1, go to SHIFT.
  - A pixel accepted at edge N therefore starts its first bit slot at edge N+1.
  - No underrun check applies to the first pixel.
- SHIFT:
  - un_encoded_data is constant for BIT_CYCLES clocks per slot.
  - When cyc_cnt==BIT_CYCLES-1 and bit_cnt<23: shift left, un_encoded_data<=shreg[22], bit_cnt++, cyc_cnt<=0, bit_strobe pulses.
  - When cyc_cnt==BIT_CYCLES-1 and bit_cnt==23 (end of pixel):
    - If sent_cnt==NUM_LEDS: go to LATCH, un_encoded_data<=0.
    - Else if hold_valid: load the next pixel with no gap (same actions as WAIT_FIRST, sent_cnt++).
    - Else: underrun<=1, go to LATCH, un_encoded_data<=0. Remaining pixels are dropped and pixel_ready deasserts.
  - A transfer and a hold-to-shreg load on the same edge are legal only if hold_valid was 0 beforehand, which pixel_ready guarantees.
- LATCH:
  - Outputs low; lat_cnt counts RESET_CYCLES clocks.
  - On the last count: frame_done pulses for 1 cycle, go to IDLE.
  - A start in the frame_done cycle is ignored; it is accepted from the next cycle.
- Timing: a full frame with no underrun takes NUM_LEDS·24·BIT_CYCLES clocks from the first bit_strobe to LATCH entry, plus RESET_CYCLES clocks to frame_done.

Test Plan:
- Nominal frame:
  - Stimulus: NUM_LEDS=2, RESET_CYCLES=100, start; pixels 0xFF0000 then 0x00AA55 with pixel_valid held high.
  - Response: 48 slots of 61 cycles. Bits are 8×1, 16×0, then 00000000 10101010 01010101. 48 bit_strobe pulses. frame_done exactly 48·61+100 clocks after the first strobe. underrun=0.
- Backpressure:
  - Stimulus: pixel_valid held high from start with a changing pixel_data.
  - Response: pixel_ready drops after the second accept while the first pixel is shifting. Exactly 2 transfers total. The second pixel's bits follow the first with no idle cycle.
- Underrun:
  - Stimulus: the second pixel is withheld until after bit 23 of the first ends.
  - Response: underrun=1 one clock after the 24th slot ends; line low; frame_done after 100 clocks; the late pixel is never accepted (pixel_ready=0).
- Reset mid-frame:
  - Stimulus: assert reset asynchronously during slot 10 of pixel 1.
  - Response: un_encoded_data, sending_data and pixel_ready go 0 immediately. After release, a fresh start transmits from bit 23 of a newly accepted pixel.
- Start while busy:
  - Stimulus: pulse start during SHIFT and during LATCH.
  - Response: no effect; the frame timing is identical to the nominal frame.
- Single LED:
  - Stimulus: NUM_LEDS=1, BIT_CYCLES=2, pixel 0x800001.
  - Response: un_encoded_data high for 2 clocks, low for 44, high for 2, then LATCH.
